// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between the instruction and data request
// lines of CPUS cores. Only one requester owns the RAM at a time, and it keeps
// ownership until RAM reports ACCESS or ERROR, or until it drops its request.
// Cores take turns round-robin, and within a core a data request beats an
// instruction request.
module ram_arbiter #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  input  logic [WORD_W-1:0]            ramload,
  input  logic [1:0]                   ramstate,
  output logic                         err
);

  localparam int unsigned CpuW = (CPUS > 1) ? $clog2(CPUS) : 1;

  // ramstate_t encoding
  localparam logic [1:0] RsFree   = 2'd0;
  localparam logic [1:0] RsBusy   = 2'd1;
  localparam logic [1:0] RsAccess = 2'd2;
  localparam logic [1:0] RsError  = 2'd3;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CpuW-1:0] own_cpu_q, own_cpu_d;
  logic            own_d_q, own_d_d;
  logic [CpuW-1:0] last_cpu_q, last_cpu_d;
  logic            err_q, err_d;

  logic            pick_valid;
  logic [CpuW-1:0] pick_cpu;
  logic            pick_data;
  logic            own_req;
  logic            granted;

  // Round-robin pick: scan from last_cpu+1 with wrap. The loop runs from the
  // farthest candidate down, so the nearest requesting core is written last.
  always_comb begin
    logic [CpuW-1:0] cand;
    pick_valid = 1'b0;
    pick_cpu   = '0;
    pick_data  = 1'b0;
    cand       = '0;
    for (int unsigned k = CPUS; k >= 1; k--) begin
      cand = CpuW'((32'(last_cpu_q) + k) % CPUS);
      if (iREN[cand] || dREN[cand] || dWEN[cand]) begin
        pick_valid = 1'b1;
        pick_cpu   = cand;
        pick_data  = dREN[cand] | dWEN[cand];
      end
    end
  end

  // The owner's request is still up; dropping it aborts the grant.
  always_comb begin
    own_req = own_d_q ? (dREN[own_cpu_q] | dWEN[own_cpu_q]) : iREN[own_cpu_q];
    granted = (state_q == StGrant) && own_req;
  end

  // RAM steering and wait generation; both are combinational within the cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (granted) begin
      if (own_d_q) begin
        ramaddr  = daddr[own_cpu_q];
        ramstore = dstore[own_cpu_q];
        ramWEN   = dWEN[own_cpu_q];
        // A write wins when a read and a write are both set.
        ramREN   = dREN[own_cpu_q] & ~dWEN[own_cpu_q];
      end else begin
        ramaddr  = iaddr[own_cpu_q];
        ramREN   = 1'b1;
      end
      if (ramstate == RsAccess) begin
        if (own_d_q) dwait[own_cpu_q] = 1'b0;
        else         iwait[own_cpu_q] = 1'b0;
      end
    end
  end

  // Send the read data to every core; the waits tell each core when it is valid.
  always_comb begin
    for (int unsigned c = 0; c < CPUS; c++) begin
      iload[c] = ramload;
      dload[c] = ramload;
    end
  end

  // Next-state logic for the FSM, the owner, the round-robin pointer and err.
  always_comb begin
    state_d    = state_q;
    own_cpu_d  = own_cpu_q;
    own_d_d    = own_d_q;
    last_cpu_d = last_cpu_q;
    err_d      = err_q;
    if (state_q == StIdle) begin
      if (pick_valid) begin
        state_d   = StGrant;
        own_cpu_d = pick_cpu;
        own_d_d   = pick_data;
      end
    end else begin
      if (!own_req) begin
        // Abort: the pointer is left alone so the same core wins the next tie.
        state_d = StIdle;
      end else if (ramstate == RsAccess) begin
        state_d    = StIdle;
        last_cpu_d = own_cpu_q;
      end else if (ramstate == RsError) begin
        state_d    = StIdle;
        last_cpu_d = own_cpu_q;
        err_d      = 1'b1;
      end else if ((ramstate == RsFree) || (ramstate == RsBusy)) begin
        state_d = StGrant;
      end
    end
  end

  // State registers with synchronous reset; core 0 wins the first arbitration.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      own_cpu_q  <= '0;
      own_d_q    <= 1'b0;
      last_cpu_q <= CpuW'(CPUS - 1);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_cpu_q  <= own_cpu_d;
      own_d_q    <= own_d_d;
      last_cpu_q <= last_cpu_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequential arbiter sharing the single RAM port between the instruction and data request lines of `CPUS` cores. Sits between the per-core cache request interface and RAM. Grants one requester at a time, holds the grant until RAM reports ACCESS, rotates fairly between cores, and gives data priority over instruction within a core. Replaces the combinational single-core steering with a registered owner so multicore traffic cannot tear a RAM transaction.

## Interface
Parameters:
- `CPUS`, 2, number of cores; legal range 1..4.
- `WORD_W`, 32, address/data width (matches `word_t`).

Ports:
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  reset; synchronous, active-high.
- `iREN`  in  CPUS  per-core instruction read request.
- `dREN`  in  CPUS  per-core data read request.
- `dWEN`  in  CPUS  per-core data write request.
- `iaddr`  in  CPUS x WORD_W  per-core instruction address.
- `daddr`  in  CPUS x WORD_W  per-core data address.
- `dstore`  in  CPUS x WORD_W  per-core write data.
- `iwait`  out  CPUS  instruction wait; 0 only in the completing cycle.
- `dwait`  out  CPUS  data wait; 0 only in the completing cycle.
- `iload`  out  CPUS x WORD_W  read data; every entry = `ramload`.
- `dload`  out  CPUS x WORD_W  read data; every entry = `ramload`.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  WORD_W  RAM address.
- `ramstore`  out  WORD_W  RAM write data.
- `ramload`  in  WORD_W  RAM read data.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- `err`  out  1  sticky flag; set on ERROR during a grant.

## Operation
- State machine: IDLE, GRANT.
- Registered owner: `own_cpu` (log2 CPUS bits) and `own_d` (1 = data port, 0 = instruction port). Round-robin pointer `last_cpu`.
- IDLE:
  - RAM enables are 0 and all waits are 1.
  - When any request is active, select a core by scanning from `last_cpu`+1 upward, with wrap-around, and taking the first core with any request.
  - Within that core, take data if `dREN|dWEN`, otherwise instruction.
  - Register the owner and go to GRANT.
- GRANT, owner's request still asserted:
  - Drive `ramaddr` from the owner's address.
  - Drive `ramstore` = owner `dstore`.
  - `ramWEN` = owner `dWEN`. `ramREN` = owner read and not `dWEN`; `dWEN` wins when both are set.
- GRANT, `ramstate`=ACCESS:
  - Owner's wait = 0 for that cycle.
  - `last_cpu` <= `own_cpu`; next state IDLE.
- GRANT, `ramstate`=ERROR: owner's wait stays 1, `err` <= 1, next state IDLE, `last_cpu` updated.
- GRANT, owner's request dropped (all of the owner port's enables are 0):
  - Abort: enables go to 0 in the same cycle and next state is IDLE.
  - No wait pulse; `last_cpu` is not updated.
- Non-owner waits are always 1.
- When nothing is driven, `ramaddr` and `ramstore` = 0 (never 'z).
- `err` is cleared only by `RST`.

## Timing
- Reset values: state IDLE, `own_cpu` 0, `own_d` 0, `last_cpu` = CPUS-1 (core 0 wins first), `err` 0. All waits are 1; `ramREN`, `ramWEN`, `ramaddr`, `ramstore` are 0.
- Request first seen high in cycle N (state IDLE): RAM is driven from cycle N+1.
- If `ramstate`=ACCESS in cycle N+k (k>=1), the owner's wait is 0 in cycle N+k and state is IDLE in N+k+1.
- The earliest regrant is cycle N+k+1, driving RAM in N+k+2, so there is one idle bubble between transactions.
- A requester that keeps its request high after completion is re-arbitrated in IDLE like any other.
- A new request arriving during GRANT has no effect until IDLE.
- Waits and RAM outputs are combinational from state, owner, requests and `ramstate`. They have no register delay within the cycle.
- `RST` asserted mid-GRANT: next cycle is IDLE with reset values; the in-flight transaction is abandoned.
- FREE or BUSY during GRANT: hold the grant.

## Test plan
- Reset → all waits 1, RAM enables 0, `err` 0. Then core0 `iREN`=1, `iaddr`=0x100 → `ramREN`=1 and `ramaddr`=0x100 from the next cycle. After 2 BUSY + 1 ACCESS cycle, `iwait[0]`=0 for exactly that ACCESS cycle.
- Core0 `dWEN`=1, `daddr`=0x200, `dstore`=0xDEADBEEF, plus core0 `iREN` at the same time → data granted first (`ramWEN`=1, `ramstore`=0xDEADBEEF). After ACCESS, a bubble cycle, then the instruction is granted.
- Core0 and core1 `dREN` continuously, 1-cycle ACCESS → grants alternate 0,1,0,1. Each `dwait` pulse is separated by 3 cycles.
- Core1 `dREN` and `dWEN` both 1 → `ramWEN`=1, `ramREN`=0.
- ERROR during core1 grant → `dwait[1]` stays 1, `err`=1 and stays 1 through later transactions until `RST`.
- Owner drops `iREN` mid-GRANT → enables 0 that cycle, IDLE next, no wait pulse, and the pointer is unchanged (same core wins the next tie). `RST` asserted mid-GRANT → reset values next cycle.
